// File: rtl/line_buffer_sched.sv
// Purpose: zero-latency round-robin arbiter over FLUX line-buffer flows, with optional burst hold.
// Latency: grant/tag/grant_valid are combinational from req/mask/stall and registered state (0 cycles).
// Backpressure: stall high suppresses every grant and freezes all registered state.
//
// Ports: clk (rising edge), rst (async, active low), req[FLUX] (flow ready to fire),
//        mask[FLUX] (0 excludes a flow), stall, grant[FLUX] (one-hot),
//        tag[TAG_WIDTH+1] (granted index, all-ones when idle), grant_valid.
// Build option: define LINE_BUFFER_SCHED_BURST_EN to let the last granted flow keep the
//        grant for up to BURST consecutive cycles; undefined gives pure round-robin
//        and no burst counter is built.
module line_buffer_sched #(
    parameter int FLUX  = 2,
    parameter int BURST = 8,
    localparam int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic [FLUX-1:0]      mask,
    input  logic                 stall,
    output logic [FLUX-1:0]      grant,
    output logic [TAG_WIDTH:0]   tag,
    output logic                 grant_valid
);

    // One extra bit so ptr + offset can exceed FLUX-1 before the modulo fold.
    localparam int SW = TAG_WIDTH + 1;

    if (FLUX < 2 || FLUX > 16 || BURST < 1 || BURST > 255) begin : g_bad_param
        $error("line_buffer_sched: FLUX must be 2..16 and BURST 1..255");
    end

    logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
    logic [TAG_WIDTH-1:0] cur_q, cur_d;
    logic                 held_q, held_d;

`ifdef LINE_BUFFER_SCHED_BURST_EN
    localparam int CNT_W = $clog2(BURST + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    logic [FLUX-1:0]      elig;
    logic                 hold_ok;
    logic                 found;
    logic [TAG_WIDTH-1:0] g_idx;
    logic [SW-1:0]        scan_sum;
    logic [TAG_WIDTH-1:0] scan_cand;

    always_comb begin
        elig      = stall ? '0 : (req & mask);
        hold_ok   = 1'b0;
        found     = 1'b0;
        g_idx     = '0;
        scan_sum  = '0;
        scan_cand = '0;

`ifdef LINE_BUFFER_SCHED_BURST_EN
        // Keep feeding the current flow until its burst quota is used up;
        // a masked or idle cur falls straight through to the rotating scan.
        hold_ok = held_q && elig[cur_q] && (cnt_q < CNT_W'(BURST));
`endif

        if (hold_ok) begin
            found = 1'b1;
            g_idx = cur_q;
        end else begin
            // First eligible flow at or after ptr, wrapping modulo FLUX.
            for (int i = 0; i < FLUX; i++) begin
                scan_sum = {1'b0, ptr_q} + SW'(i);
                if (scan_sum >= SW'(FLUX)) begin
                    scan_sum = scan_sum - SW'(FLUX);
                end
                scan_cand = scan_sum[TAG_WIDTH-1:0];
                if (!found && elig[scan_cand]) begin
                    found = 1'b1;
                    g_idx = scan_cand;
                end
            end
        end
    end

    always_comb begin
        grant       = '0;
        tag         = '1;
        grant_valid = found;
        if (found) begin
            grant = FLUX'(1) << g_idx;
            tag   = {1'b0, g_idx};
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        cur_d  = cur_q;
        held_d = held_q;
`ifdef LINE_BUFFER_SCHED_BURST_EN
        cnt_d  = cnt_q;
`endif
        if (!stall) begin
            if (found) begin
                cur_d  = g_idx;
                held_d = 1'b1;
                ptr_d  = (g_idx == TAG_WIDTH'(FLUX - 1)) ? '0 : g_idx + TAG_WIDTH'(1);
`ifdef LINE_BUFFER_SCHED_BURST_EN
                // A re-grant of cur after the quota ran out (sole eligible flow)
                // starts a fresh burst rather than counting past BURST.
                if (held_q && (g_idx == cur_q) && (cnt_q < CNT_W'(BURST))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(1);
                end
`endif
            end else begin
                // An idle cycle breaks the burst; ptr and cnt keep their values.
                held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= '0;
            cur_q  <= '0;
            held_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cur_q  <= cur_d;
            held_q <= held_d;
        end
    end

`ifdef LINE_BUFFER_SCHED_BURST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_sched.sv
// Purpose: directed self-checking bench for line_buffer_sched (FLUX=4, BURST=3).
// Latency: outputs are checked 1 time unit after inputs change, mid low phase of clk.
// Backpressure: stall scenario checks grants are suppressed and state is frozen.
module tb_line_buffer_sched;

    localparam int FLUX  = 4;
    localparam int BURST = 3;

`ifdef LINE_BUFFER_SCHED_BURST_EN
    localparam bit BM = 1'b1;
`else
    localparam bit BM = 1'b0;
`endif

    // Expected granted flow per cycle, -1 meaning no grant.
    localparam int ROT_B [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    localparam int ROT_R [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    localparam int CNT_SEQ [7] = '{1, 2, 3, 1, 2, 3, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] mask = 4'b1111;
    logic       stall = 1'b0;
    logic [3:0] grant;
    logic [2:0] tag;
    logic       grant_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    line_buffer_sched #(.FLUX(FLUX), .BURST(BURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .stall       (stall),
        .grant       (grant),
        .tag         (tag),
        .grant_valid (grant_valid)
    );

    // Expected {grant, tag, grant_valid} for flow e, or the idle pattern for e < 0.
    function automatic logic [7:0] exp_vec(input int e);
        logic [1:0] t;
        if (e < 0) return {4'b0000, 3'b111, 1'b0};
        t = e[1:0];
        return {4'b0001 << t, 1'b0, t, 1'b1};
    endfunction

    task automatic apply_reset();
        rst   = 1'b0;
        req   = 4'b0000;
        mask  = 4'b1111;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b0; req = 4'b1111; mask = 4'b1111; stall = 1'b0;
        @(negedge clk); #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(0)) begin
            n_err++; $display("FAIL reset_all_req: got %b want %b", obs, exp_vec(0));
        end
        req = 4'b0000; #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(-1)) begin
            n_err++; $display("FAIL reset_idle: got %b want %b", obs, exp_vec(-1));
        end
        req = 4'b0110;
        @(negedge clk); #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(1)) begin
            n_err++; $display("FAIL reset_scan_from_0: got %b want %b", obs, exp_vec(1));
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [7:0] obs;
        int e;
        apply_reset();
        req = 4'b1111; mask = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            #1;
            e = BM ? ROT_B[i] : ROT_R[i];
            obs = {grant, tag, grant_valid};
            n_vec++;
            if (obs !== exp_vec(e)) begin
                n_err++; $display("FAIL rotation[%0d]: got %b want %b", i, obs, exp_vec(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_flow();
        logic [7:0] obs;
        apply_reset();
        req = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            #1;
            obs = {grant, tag, grant_valid};
            n_vec++;
            if (obs !== exp_vec(2)) begin
                n_err++; $display("FAIL single_flow[%0d]: got %b want %b", i, obs, exp_vec(2));
            end
`ifdef LINE_BUFFER_SCHED_BURST_EN
            @(posedge clk); #1;
            n_vec++;
            if (int'(dut.cnt_q) !== CNT_SEQ[i]) begin
                n_err++; $display("FAIL single_flow_cnt[%0d]: got %0d want %0d", i, dut.cnt_q, CNT_SEQ[i]);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_idle();
        logic [7:0] obs;
        apply_reset();
        req = 4'b1111;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = {grant, tag, grant_valid};
            n_vec++;
            if (obs !== exp_vec(-1)) begin
                n_err++; $display("FAIL idle[%0d]: got %b want %b", i, obs, exp_vec(-1));
            end
            @(negedge clk);
        end
        req = 4'b1000; #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(3)) begin
            n_err++; $display("FAIL idle_then_flow3: got %b want %b", obs, exp_vec(3));
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [7:0] obs;
        int e;
        apply_reset();
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        req = 4'b1111; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            obs = {grant, tag, grant_valid};
            n_vec++;
            if (obs !== exp_vec(-1)) begin
                n_err++; $display("FAIL stall[%0d]: got %b want %b", i, obs, exp_vec(-1));
            end
            @(negedge clk);
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            e = BM ? ((i == 0) ? 1 : 2) : ((i == 0) ? 2 : 3);
            obs = {grant, tag, grant_valid};
            n_vec++;
            if (obs !== exp_vec(e)) begin
                n_err++; $display("FAIL stall_release[%0d]: got %b want %b", i, obs, exp_vec(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mask_drop();
        logic [7:0] obs;
        int e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req  = (i == 0) ? 4'b0100 : 4'b0101;
            mask = (i == 2) ? 4'b1011 : 4'b1111;
            #1;
            e = (i == 0) ? 2 : (i == 2) ? 0 : (BM ? 2 : 0);
            obs = {grant, tag, grant_valid};
            n_vec++;
            if (obs !== exp_vec(e)) begin
                n_err++; $display("FAIL mask_drop[%0d]: got %b want %b", i, obs, exp_vec(e));
            end
            @(negedge clk);
        end
        mask = 4'b1111;
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] obs;
        apply_reset();
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0011; #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(BM ? 1 : 0)) begin
            n_err++; $display("FAIL pre_reset_hold: got %b want %b", obs, exp_vec(BM ? 1 : 0));
        end
        #1 rst = 1'b0;
        #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(0)) begin
            n_err++; $display("FAIL async_reset: got %b want %b", obs, exp_vec(0));
        end
        @(negedge clk);
        rst = 1'b1; #1;
        obs = {grant, tag, grant_valid};
        n_vec++;
        if (obs !== exp_vec(0)) begin
            n_err++; $display("FAIL post_reset_first: got %b want %b", obs, exp_vec(0));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_single_flow();
        test_idle();
        test_stall();
        test_mask_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer_sched.md
LINE_BUFFER_SCHED -- requirements
Module: line_buffer_sched

Interface
- REQ-001: FLUX, default 2, is the number of tagged flows arbitrated; legal range is 2..16.
- REQ-002: BURST, default 8, is the maximum number of consecutive grants to one flow before priority rotates; legal range is 1..255.
- REQ-003: TAG_WIDTH, derived as $clog2(FLUX), is not user-set.
- REQ-004: clk  input  1  is the single clock; all state updates on its rising edge.
- REQ-005: rst  input  1  is the asynchronous, active-low reset.
- REQ-006: req  input  FLUX  bit i high means flow i meets its firing condition this cycle, as computed by the line buffer.
- REQ-007: mask  input  FLUX  bit i low excludes flow i from arbitration.
- REQ-008: stall  input  1  when high, suppresses all grants and freezes state.
- REQ-009: grant  output  FLUX  is the one-hot grant vector, combinational from inputs and registered state.
- REQ-010: tag  output  TAG_WIDTH+1  is the binary index of the granted flow with MSB 0, or all-ones when no flow is granted.
- REQ-011: grant_valid  output  1  is high when exactly one grant bit is set.

Function
- REQ-012: The eligible set SHALL be req AND mask, forced to zero while stall is high.
- REQ-013: When the eligible set is empty, grant SHALL be 0, tag SHALL be all-ones and grant_valid SHALL be 0.
- REQ-014: Zero latency: the grant SHALL appear in the same cycle as the qualifying req; the datapath fires on that edge.
- REQ-015: Registered state SHALL be ptr (TAG_WIDTH bits), cur (TAG_WIDTH bits), cnt ($clog2(BURST+1) bits) and held (1 bit).
- REQ-016: HOLD rule: if held=1, flow cur is eligible and cnt<BURST, the grant SHALL go to cur.
- REQ-017: Otherwise the grant SHALL go to the first eligible flow found by scanning ptr, ptr+1, ... modulo FLUX.
- REQ-018: On a cycle with a grant to flow g: cur<=g; held<=1; ptr<=(g+1) mod FLUX, with FLUX-1 wrapping to 0.
- REQ-019: On the same grant cycle, cnt<=cnt+1 if g equals the previous cur and held=1, otherwise cnt<=1.
- REQ-020: When cnt reaches BURST, the next arbitration SHALL ignore HOLD, so the scan from ptr selects a different eligible flow if one exists.
- REQ-021: If flow cur is the only eligible flow and cnt=BURST, cur SHALL be re-granted and cnt SHALL restart at 1; the arbiter never idles while any flow is eligible.
- REQ-022: On a cycle with no grant and stall low, held SHALL clear to 0 and ptr and cnt SHALL hold.
- REQ-023: While stall is high, every register SHALL hold its value.
- REQ-024: A mask bit dropping on flow cur SHALL take effect in the same cycle, with no grant to that flow.
- REQ-025: Fairness: any continuously eligible flow SHALL be granted within (FLUX-1)*BURST+1 cycles.

Reset
- REQ-026: Asserting rst low SHALL asynchronously set ptr=0, cur=0, cnt=0 and held=0.
- REQ-027: During and immediately after reset, outputs SHALL follow REQ-013 and REQ-017 from ptr=0.
- REQ-028: Reset asserted mid-burst SHALL discard burst history; the first grant after release SHALL be the lowest-index eligible flow.
- REQ-029: Deassertion of rst SHALL be synchronous to clk by construction at the integration level; the block adds no synchronizer.

Configuration
- REQ-030: Macro LINE_BUFFER_SCHED_BURST_EN selects the arbitration mode.
- REQ-031: With LINE_BUFFER_SCHED_BURST_EN defined, REQ-016, REQ-019 to REQ-021 and the BURST parameter apply.
- REQ-032: Without LINE_BUFFER_SCHED_BURST_EN, HOLD SHALL be disabled, the cnt register SHALL not be generated, and every grant SHALL follow pure round-robin from ptr (equivalent to BURST=1).

Verification
(Bench parameters: FLUX=4, BURST=3, macro defined unless noted.)
- REQ-033: Reset release, req=4'b1111, mask=4'b1111 -> grants 0,0,0,1,1,1,2,2,2,3,3,3,0; tag follows the same sequence.
- REQ-034: req=4'b0100 only, held for 7 cycles -> tag=2 every cycle; cnt sequence is 1,2,3,1,2,3,1.
- REQ-035: req=4'b0000 -> tag=3'b111, grant=0, grant_valid=0; next req=4'b1000 after an idle cycle -> grant=4'b1000 immediately.
- REQ-036: Flow 1 bursting with cnt=2; stall high for 4 cycles -> grant=0 throughout; on stall release, flow 1 is granted once more, then rotation moves to the next eligible flow.
- REQ-037: Flow 2 bursting; mask[2] drops while req=4'b0101 -> same-cycle grant to flow 0, the first eligible flow scanning from ptr=3 with wrap.
- REQ-038: Macro undefined, req=4'b1111 -> grants 0,1,2,3,0,1 in successive cycles.
